// File: rtl/five_tuple_lookup_arbiter_if.sv
// Bundle of the two extractor channels, the lookup-engine handshake and the descriptor handshake.
// master = arbiter side, slave = extractors/lookup engine/downstream side.
interface five_tuple_lookup_arbiter_if;
  logic [103:0] iv_5tuple_data0;
  logic         i_5tuple_wr0;
  logic [8:0]   iv_bufid0;
  logic [103:0] iv_5tuple_data1;
  logic         i_5tuple_wr1;
  logic [8:0]   iv_bufid1;

  logic [103:0] ov_lookup_key;
  logic         o_lookup_req;
  logic         i_lookup_ack;
  logic         i_lookup_hit;
  logic [47:0]  iv_lookup_tsntag;

  logic [47:0]  ov_tsntag;
  logic [8:0]   ov_bufid;
  logic         o_channel;
  logic         o_hit;
  logic         o_descriptor_wr;
  logic         i_descriptor_ack;

  modport master (
    input  iv_5tuple_data0, i_5tuple_wr0, iv_bufid0,
    input  iv_5tuple_data1, i_5tuple_wr1, iv_bufid1,
    output ov_lookup_key, o_lookup_req,
    input  i_lookup_ack, i_lookup_hit, iv_lookup_tsntag,
    output ov_tsntag, ov_bufid, o_channel, o_hit, o_descriptor_wr,
    input  i_descriptor_ack
  );

  modport slave (
    output iv_5tuple_data0, i_5tuple_wr0, iv_bufid0,
    output iv_5tuple_data1, i_5tuple_wr1, iv_bufid1,
    input  ov_lookup_key, o_lookup_req,
    output i_lookup_ack, i_lookup_hit, iv_lookup_tsntag,
    input  ov_tsntag, ov_bufid, o_channel, o_hit, o_descriptor_wr,
    output i_descriptor_ack
  );
endinterface

// File: rtl/five_tuple_lookup_arbiter.sv
// Round-robin arbiter sharing one flow-table lookup engine between two 5-tuple channels.
// Optional per-channel drop counters are enabled with the macro FTLA_DROP_CNT_EN.
//
// Handshakes: o_lookup_req is a level held until a single-cycle i_lookup_ack (result valid
// in that cycle) or until the timeout forces a miss; o_descriptor_wr is a level held, with
// all descriptor fields stable, until the cycle i_descriptor_ack is sampled high.
module five_tuple_lookup_arbiter #(
  parameter int TIMEOUT_CYCLES = 16
`ifdef FTLA_DROP_CNT_EN
  ,
  parameter int DROP_CNT_W     = 16
`endif
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  five_tuple_lookup_arbiter_if.master    bus,
`ifdef FTLA_DROP_CNT_EN
  output logic [DROP_CNT_W-1:0]          ov_drop_cnt0,
  output logic [DROP_CNT_W-1:0]          ov_drop_cnt1,
`endif
  output logic [1:0]                     ov_dbg_state
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE_S   = 2'd0,
    LOOKUP_S = 2'd1,
    OUTPUT_S = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic         slot0_valid_q, slot0_valid_d;
  logic [103:0] slot0_key_q, slot0_key_d;
  logic [8:0]   slot0_bufid_q, slot0_bufid_d;
  logic         slot1_valid_q, slot1_valid_d;
  logic [103:0] slot1_key_q, slot1_key_d;
  logic [8:0]   slot1_bufid_q, slot1_bufid_d;

  logic [8:0]       work_bufid_q, work_bufid_d;
  logic             work_ch_q, work_ch_d;
  logic             last_grant_q, last_grant_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic [103:0] lookup_key_q, lookup_key_d;
  logic         lookup_req_q, lookup_req_d;
  logic [47:0]  tsntag_q, tsntag_d;
  logic [8:0]   bufid_q, bufid_d;
  logic         channel_q, channel_d;
  logic         hit_q, hit_d;
  logic         desc_wr_q, desc_wr_d;

  logic grant_valid, grant_ch, lookup_timeout, lookup_done;
  logic free0, free1, take0, take1, drop0, drop1;

  // Arbitration happens only in IDLE_S; on contention the channel not granted last wins.
  always_comb begin
    grant_valid    = (state_q == IDLE_S) && (slot0_valid_q || slot1_valid_q);
    grant_ch       = (slot0_valid_q && slot1_valid_q) ? ~last_grant_q : slot1_valid_q;
    lookup_timeout = (state_q == LOOKUP_S) && !bus.i_lookup_ack && (timer_q == TMR_LAST);
    lookup_done    = (state_q == LOOKUP_S) && (bus.i_lookup_ack || (timer_q == TMR_LAST));
    free0          = grant_valid && !grant_ch;
    free1          = grant_valid && grant_ch;
    take0          = bus.i_5tuple_wr0 && (!slot0_valid_q || free0);
    take1          = bus.i_5tuple_wr1 && (!slot1_valid_q || free1);
    drop0          = bus.i_5tuple_wr0 && !take0;
    drop1          = bus.i_5tuple_wr1 && !take1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE_S;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_S:   if (grant_valid) state_d = LOOKUP_S;
      LOOKUP_S: if (lookup_done) state_d = OUTPUT_S;
      OUTPUT_S: if (bus.i_descriptor_ack) state_d = IDLE_S;
      default:  state_d = IDLE_S;
    endcase
  end

  always_comb begin
    slot0_valid_d = take0 ? 1'b1 : (free0 ? 1'b0 : slot0_valid_q);
    slot0_key_d   = take0 ? bus.iv_5tuple_data0 : slot0_key_q;
    slot0_bufid_d = take0 ? bus.iv_bufid0 : slot0_bufid_q;
    slot1_valid_d = take1 ? 1'b1 : (free1 ? 1'b0 : slot1_valid_q);
    slot1_key_d   = take1 ? bus.iv_5tuple_data1 : slot1_key_q;
    slot1_bufid_d = take1 ? bus.iv_bufid1 : slot1_bufid_q;

    work_bufid_d  = work_bufid_q;
    work_ch_d     = work_ch_q;
    last_grant_d  = last_grant_q;
    timer_d       = timer_q;
    lookup_key_d  = lookup_key_q;
    lookup_req_d  = lookup_req_q;
    tsntag_d      = tsntag_q;
    bufid_d       = bufid_q;
    channel_d     = channel_q;
    hit_d         = hit_q;
    desc_wr_d     = desc_wr_q;

    case (state_q)
      IDLE_S: begin
        if (grant_valid) begin
          lookup_key_d = grant_ch ? slot1_key_q : slot0_key_q;
          work_bufid_d = grant_ch ? slot1_bufid_q : slot0_bufid_q;
          work_ch_d    = grant_ch;
          last_grant_d = grant_ch;
          lookup_req_d = 1'b1;
          timer_d      = '0;
        end
      end
      LOOKUP_S: begin
        // An ack arriving on the final timer cycle still delivers the real result.
        if (lookup_done) begin
          lookup_req_d = 1'b0;
          hit_d        = bus.i_lookup_ack && bus.i_lookup_hit;
          tsntag_d     = (bus.i_lookup_ack && bus.i_lookup_hit) ? bus.iv_lookup_tsntag : 48'h0;
          bufid_d      = work_bufid_q;
          channel_d    = work_ch_q;
          desc_wr_d    = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      OUTPUT_S: begin
        if (bus.i_descriptor_ack) begin
          desc_wr_d = 1'b0;
          tsntag_d  = '0;
          bufid_d   = '0;
          hit_d     = 1'b0;
        end
      end
      default: begin
        lookup_req_d = 1'b0;
        desc_wr_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot0_valid_q <= 1'b0;
      slot0_key_q   <= '0;
      slot0_bufid_q <= '0;
      slot1_valid_q <= 1'b0;
      slot1_key_q   <= '0;
      slot1_bufid_q <= '0;
      work_bufid_q  <= '0;
      work_ch_q     <= 1'b0;
      last_grant_q  <= 1'b1;
      timer_q       <= '0;
      lookup_key_q  <= '0;
      lookup_req_q  <= 1'b0;
      tsntag_q      <= '0;
      bufid_q       <= '0;
      channel_q     <= 1'b0;
      hit_q         <= 1'b0;
      desc_wr_q     <= 1'b0;
    end else begin
      slot0_valid_q <= slot0_valid_d;
      slot0_key_q   <= slot0_key_d;
      slot0_bufid_q <= slot0_bufid_d;
      slot1_valid_q <= slot1_valid_d;
      slot1_key_q   <= slot1_key_d;
      slot1_bufid_q <= slot1_bufid_d;
      work_bufid_q  <= work_bufid_d;
      work_ch_q     <= work_ch_d;
      last_grant_q  <= last_grant_d;
      timer_q       <= timer_d;
      lookup_key_q  <= lookup_key_d;
      lookup_req_q  <= lookup_req_d;
      tsntag_q      <= tsntag_d;
      bufid_q       <= bufid_d;
      channel_q     <= channel_d;
      hit_q         <= hit_d;
      desc_wr_q     <= desc_wr_d;
    end
  end

`ifdef FTLA_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt0_q, drop_cnt0_d, drop_cnt1_q, drop_cnt1_d;

  // Saturating: a counter stuck at all-ones means "at least that many".
  always_comb begin
    drop_cnt0_d = (drop0 && (drop_cnt0_q != '1)) ? drop_cnt0_q + 1'b1 : drop_cnt0_q;
    drop_cnt1_d = (drop1 && (drop_cnt1_q != '1)) ? drop_cnt1_q + 1'b1 : drop_cnt1_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      drop_cnt0_q <= '0;
      drop_cnt1_q <= '0;
    end else begin
      drop_cnt0_q <= drop_cnt0_d;
      drop_cnt1_q <= drop_cnt1_d;
    end
  end

  assign ov_drop_cnt0 = drop_cnt0_q;
  assign ov_drop_cnt1 = drop_cnt1_q;
`else
  logic unused_drops;
  assign unused_drops = drop0 ^ drop1;
`endif

  assign bus.ov_lookup_key   = lookup_key_q;
  assign bus.o_lookup_req    = lookup_req_q;
  assign bus.ov_tsntag       = tsntag_q;
  assign bus.ov_bufid        = bufid_q;
  assign bus.o_channel       = channel_q;
  assign bus.o_hit           = hit_q;
  assign bus.o_descriptor_wr = desc_wr_q;
  assign ov_dbg_state        = state_q;

endmodule

// File: tb/tb_five_tuple_lookup_arbiter.sv
// Directed bench for five_tuple_lookup_arbiter: hit path, round robin, timeout, drops,
// descriptor backpressure and mid-lookup reset.
module tb_five_tuple_lookup_arbiter;
  logic       i_clk;
  logic       i_rst_n;
  logic [1:0] dbg_state;
`ifdef FTLA_DROP_CNT_EN
  logic [15:0] drop_cnt0, drop_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  five_tuple_lookup_arbiter_if bus();

  five_tuple_lookup_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .bus          (bus),
`ifdef FTLA_DROP_CNT_EN
    .ov_drop_cnt0 (drop_cnt0),
    .ov_drop_cnt1 (drop_cnt1),
`endif
    .ov_dbg_state (dbg_state)
  );

  // clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.iv_5tuple_data0  = '0;
    bus.i_5tuple_wr0     = 1'b0;
    bus.iv_bufid0        = '0;
    bus.iv_5tuple_data1  = '0;
    bus.i_5tuple_wr1     = 1'b0;
    bus.iv_bufid1        = '0;
    bus.i_lookup_ack     = 1'b0;
    bus.i_lookup_hit     = 1'b0;
    bus.iv_lookup_tsntag = '0;
    bus.i_descriptor_ack = 1'b0;
  endtask

  task automatic apply_reset;
    i_rst_n = 1'b0;
    clear_inputs();
    step();
    step();
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic pulse_wr(input bit ch, input logic [103:0] key, input logic [8:0] bufid);
    if (ch) begin
      bus.iv_5tuple_data1 = key;
      bus.iv_bufid1       = bufid;
      bus.i_5tuple_wr1    = 1'b1;
    end else begin
      bus.iv_5tuple_data0 = key;
      bus.iv_bufid0       = bufid;
      bus.i_5tuple_wr0    = 1'b1;
    end
    step();
    bus.i_5tuple_wr0 = 1'b0;
    bus.i_5tuple_wr1 = 1'b0;
  endtask

  task automatic wait_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.o_lookup_req) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic ack_lookup(input bit hit, input logic [47:0] tag);
    bus.i_lookup_ack     = 1'b1;
    bus.i_lookup_hit     = hit;
    bus.iv_lookup_tsntag = tag;
    step();
    bus.i_lookup_ack     = 1'b0;
    bus.i_lookup_hit     = 1'b0;
    bus.iv_lookup_tsntag = '0;
  endtask

  task automatic ack_desc;
    bus.i_descriptor_ack = 1'b1;
    step();
    bus.i_descriptor_ack = 1'b0;
  endtask

  // scenarios
  task automatic test_reset;
    apply_reset();
    checks++;
    if ({bus.o_lookup_req, bus.o_descriptor_wr, bus.o_hit, bus.o_channel} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_handshake: got req/wr/hit/ch=%b expected 0000",
               {bus.o_lookup_req, bus.o_descriptor_wr, bus.o_hit, bus.o_channel});
    end
    checks++;
    if (bus.ov_tsntag !== 48'h0 || bus.ov_bufid !== 9'h0 || bus.ov_lookup_key !== 104'h0) begin
      errors++;
      $display("FAIL reset_data: got tag=%h bufid=%h key=%h expected zeros",
               bus.ov_tsntag, bus.ov_bufid, bus.ov_lookup_key);
    end
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", dbg_state);
    end
  endtask

  task automatic test_hit;
    logic [103:0] key;
    bit ok;
    key = {8'h06, 32'hC0A8_0001, 32'hC0A8_0002, 16'd1000, 16'd80};
    apply_reset();
    pulse_wr(1'b0, key, 9'h012);
    wait_req(8, ok);
    checks++;
    if (!ok || bus.ov_lookup_key !== key) begin
      errors++;
      $display("FAIL hit_req: got req=%b key=%h expected req=1 key=%h", ok, bus.ov_lookup_key, key);
    end
    step();
    step();
    checks++;
    if (bus.o_lookup_req !== 1'b1 || bus.o_descriptor_wr !== 1'b0) begin
      errors++;
      $display("FAIL hit_req_held: got req=%b wr=%b expected req=1 wr=0",
               bus.o_lookup_req, bus.o_descriptor_wr);
    end
    ack_lookup(1'b1, 48'h0000_0000_00A5);
    checks++;
    if ({bus.o_lookup_req, bus.o_descriptor_wr, bus.o_hit, bus.o_channel} !== 4'b0110 ||
        bus.ov_tsntag !== 48'h0000_0000_00A5 || bus.ov_bufid !== 9'h012) begin
      errors++;
      $display("FAIL hit_desc: got req/wr/hit/ch=%b tag=%h bufid=%h expected 0110 tag=a5 bufid=012",
               {bus.o_lookup_req, bus.o_descriptor_wr, bus.o_hit, bus.o_channel},
               bus.ov_tsntag, bus.ov_bufid);
    end
    ack_desc();
    checks++;
    if (bus.o_descriptor_wr !== 1'b0 || bus.ov_tsntag !== 48'h0 || bus.ov_bufid !== 9'h0 ||
        bus.o_hit !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL hit_release: got wr=%b tag=%h bufid=%h hit=%b state=%0d expected all 0",
               bus.o_descriptor_wr, bus.ov_tsntag, bus.ov_bufid, bus.o_hit, dbg_state);
    end
  endtask

  task automatic test_round_robin;
    logic [103:0] k0, k1, exp_key;
    logic [8:0]   exp_bufid;
    bit ok;
    apply_reset();
    for (int rep = 0; rep < 2; rep++) begin
      k0 = {8'h11, 32'h0A00_0001, 32'h0A00_0100 + rep, 16'd5000, 16'd53};
      k1 = {8'h06, 32'h0B00_0001, 32'h0B00_0200 + rep, 16'd6000, 16'd443};
      bus.iv_5tuple_data0 = k0;
      bus.iv_bufid0       = 9'h021 + 9'(rep);
      bus.i_5tuple_wr0    = 1'b1;
      bus.iv_5tuple_data1 = k1;
      bus.iv_bufid1       = 9'h1E0 + 9'(rep);
      bus.i_5tuple_wr1    = 1'b1;
      step();
      bus.i_5tuple_wr0 = 1'b0;
      bus.i_5tuple_wr1 = 1'b0;
      for (int k = 0; k < 2; k++) begin
        exp_key   = (k == 0) ? k0 : k1;
        exp_bufid = (k == 0) ? (9'h021 + 9'(rep)) : (9'h1E0 + 9'(rep));
        wait_req(8, ok);
        checks++;
        if (!ok || bus.ov_lookup_key !== exp_key) begin
          errors++;
          $display("FAIL rr_key rep%0d slot%0d: got req=%b key=%h expected key=%h",
                   rep, k, ok, bus.ov_lookup_key, exp_key);
        end
        ack_lookup(1'b1, 48'hBEEF_0000_0000 + 48'(k));
        checks++;
        if (bus.o_descriptor_wr !== 1'b1 || bus.o_channel !== 1'(k) || bus.ov_bufid !== exp_bufid ||
            bus.ov_tsntag !== 48'hBEEF_0000_0000 + 48'(k)) begin
          errors++;
          $display("FAIL rr_desc rep%0d slot%0d: got wr=%b ch=%b bufid=%h tag=%h expected wr=1 ch=%0d bufid=%h",
                   rep, k, bus.o_descriptor_wr, bus.o_channel, bus.ov_bufid, bus.ov_tsntag, k, exp_bufid);
        end
        ack_desc();
      end
    end
  endtask

  task automatic test_timeout;
    logic [103:0] key;
    int cnt;
    bit ok;
    key = {8'h01, 32'h7F00_0001, 32'h7F00_0002, 16'd0, 16'd0};
    apply_reset();
    pulse_wr(1'b0, key, 9'h155);
    wait_req(8, ok);
    cnt = 0;
    while (bus.o_lookup_req && cnt < 40) begin
      cnt++;
      step();
    end
    checks++;
    if (!ok || cnt != 16) begin
      errors++;
      $display("FAIL timeout_len: got req cycles=%0d expected 16", cnt);
    end
    checks++;
    if (bus.o_descriptor_wr !== 1'b1 || bus.o_hit !== 1'b0 || bus.ov_tsntag !== 48'h0 ||
        bus.ov_bufid !== 9'h155 || bus.o_channel !== 1'b0) begin
      errors++;
      $display("FAIL timeout_desc: got wr=%b hit=%b tag=%h bufid=%h ch=%b expected wr=1 hit=0 tag=0 bufid=155 ch=0",
               bus.o_descriptor_wr, bus.o_hit, bus.ov_tsntag, bus.ov_bufid, bus.o_channel);
    end
    ack_desc();
  endtask

  task automatic test_drop;
    logic [103:0] ka, kb, kc;
    bit ok, seen_req;
    ka = {8'h06, 32'h0101_0101, 32'h0202_0202, 16'd1, 16'd2};
    kb = {8'h06, 32'h0303_0303, 32'h0404_0404, 16'd3, 16'd4};
    kc = {8'h06, 32'h0505_0505, 32'h0606_0606, 16'd5, 16'd6};
    apply_reset();
    bus.i_5tuple_wr0 = 1'b1;
    bus.iv_5tuple_data0 = ka; bus.iv_bufid0 = 9'h0A1;
    step();
    bus.iv_5tuple_data0 = kb; bus.iv_bufid0 = 9'h0B2;
    step();
    bus.iv_5tuple_data0 = kc; bus.iv_bufid0 = 9'h0C3;
    step();
    bus.i_5tuple_wr0 = 1'b0;
    checks++;
    if (bus.o_lookup_req !== 1'b1 || bus.ov_lookup_key !== ka) begin
      errors++;
      $display("FAIL drop_first_req: got req=%b key=%h expected req=1 key=%h",
               bus.o_lookup_req, bus.ov_lookup_key, ka);
    end
    repeat (3) step();
    ack_lookup(1'b0, 48'hFFFF_FFFF_FFFF);
    checks++;
    if (bus.ov_bufid !== 9'h0A1 || bus.o_hit !== 1'b0 || bus.ov_tsntag !== 48'h0) begin
      errors++;
      $display("FAIL drop_first_desc: got bufid=%h hit=%b tag=%h expected bufid=0a1 hit=0 tag=0",
               bus.ov_bufid, bus.o_hit, bus.ov_tsntag);
    end
    ack_desc();
    wait_req(8, ok);
    checks++;
    if (!ok || bus.ov_lookup_key !== kb) begin
      errors++;
      $display("FAIL drop_second_req: got req=%b key=%h expected key=%h", ok, bus.ov_lookup_key, kb);
    end
    ack_lookup(1'b1, 48'h0000_0000_0B0B);
    checks++;
    if (bus.ov_bufid !== 9'h0B2 || bus.o_hit !== 1'b1) begin
      errors++;
      $display("FAIL drop_second_desc: got bufid=%h hit=%b expected bufid=0b2 hit=1",
               bus.ov_bufid, bus.o_hit);
    end
    ack_desc();
    seen_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.o_lookup_req) seen_req = 1'b1;
      step();
    end
    checks++;
    if (seen_req !== 1'b0) begin
      errors++;
      $display("FAIL drop_third_dropped: got extra req=%b expected 0", seen_req);
    end
`ifdef FTLA_DROP_CNT_EN
    checks++;
    if (drop_cnt0 !== 16'd1 || drop_cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL drop_cnt: got cnt0=%0d cnt1=%0d expected 1 0", drop_cnt0, drop_cnt1);
    end
`endif
  endtask

  task automatic test_desc_stall;
    logic [103:0] k0, k1;
    bit ok;
    k0 = {8'h11, 32'hAC10_0001, 32'hAC10_0002, 16'd7, 16'd8};
    k1 = {8'h11, 32'hAC10_0003, 32'hAC10_0004, 16'd9, 16'd10};
    apply_reset();
    pulse_wr(1'b0, k0, 9'h0AB);
    wait_req(8, ok);
    ack_lookup(1'b1, 48'h1234_5678_9ABC);
    pulse_wr(1'b1, k1, 9'h1CD);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.o_descriptor_wr !== 1'b1 || bus.ov_tsntag !== 48'h1234_5678_9ABC ||
          bus.ov_bufid !== 9'h0AB || bus.o_hit !== 1'b1 || bus.o_channel !== 1'b0 ||
          bus.o_lookup_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc%0d: got wr=%b tag=%h bufid=%h hit=%b ch=%b req=%b expected 1 123456789abc 0ab 1 0 0",
                 i, bus.o_descriptor_wr, bus.ov_tsntag, bus.ov_bufid, bus.o_hit,
                 bus.o_channel, bus.o_lookup_req);
      end
      step();
    end
    ack_desc();
    wait_req(8, ok);
    checks++;
    if (!ok || bus.ov_lookup_key !== k1) begin
      errors++;
      $display("FAIL stall_next_req: got req=%b key=%h expected key=%h", ok, bus.ov_lookup_key, k1);
    end
    ack_lookup(1'b1, 48'h0000_0000_0001);
    checks++;
    if (bus.o_channel !== 1'b1 || bus.ov_bufid !== 9'h1CD) begin
      errors++;
      $display("FAIL stall_next_desc: got ch=%b bufid=%h expected ch=1 bufid=1cd",
               bus.o_channel, bus.ov_bufid);
    end
    ack_desc();
  endtask

  task automatic test_reset_mid;
    logic [103:0] k0, k1, k2;
    bit ok, seen_req;
    k0 = {8'h06, 32'hDEAD_0001, 32'hBEEF_0001, 16'd11, 16'd12};
    k1 = {8'h06, 32'hDEAD_0002, 32'hBEEF_0002, 16'd13, 16'd14};
    k2 = {8'h11, 32'hDEAD_0003, 32'hBEEF_0003, 16'd15, 16'd16};
    apply_reset();
    pulse_wr(1'b0, k0, 9'h011);
    wait_req(8, ok);
    pulse_wr(1'b1, k1, 9'h022);
    checks++;
    if (!ok || dbg_state !== 2'd1 || bus.o_lookup_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got state=%0d req=%b expected state=1 req=1", dbg_state, bus.o_lookup_req);
    end
    #3;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_lookup_req !== 1'b0 || bus.o_descriptor_wr !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_async: got req=%b wr=%b state=%0d expected 0 0 0",
               bus.o_lookup_req, bus.o_descriptor_wr, dbg_state);
    end
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    seen_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.o_lookup_req) seen_req = 1'b1;
    end
    checks++;
    if (seen_req !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_slots_cleared: got req seen=%b expected 0", seen_req);
    end
    pulse_wr(1'b1, k2, 9'h033);
    wait_req(8, ok);
    checks++;
    if (!ok || bus.ov_lookup_key !== k2) begin
      errors++;
      $display("FAIL rstmid_post_req: got req=%b key=%h expected key=%h", ok, bus.ov_lookup_key, k2);
    end
    ack_lookup(1'b1, 48'h0000_0000_0033);
    checks++;
    if (bus.o_channel !== 1'b1 || bus.ov_bufid !== 9'h033 || bus.o_descriptor_wr !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_post_desc: got ch=%b bufid=%h wr=%b expected ch=1 bufid=033 wr=1",
               bus.o_channel, bus.ov_bufid, bus.o_descriptor_wr);
    end
    ack_desc();
  endtask

  // sequence and final report
  initial begin
    i_rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_hit();
    test_round_robin();
    test_timeout();
    test_drop();
    test_desc_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
